mod_p_shift_seq: RTL

MOD_P_SHIFT_SEQ -- requirements
Module: mod_p_shift_seq

---
 rtl/mod_p_shift_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mod_p_shift_seq.sv
// mod_p_shift_seq: computes b*x^k mod p(x) = x^M + x^T + 2 over GF(3), one x-step per clock.
// Optional feature macro INVERSE_SHIFT_EN adds the dir port and the multiply-by-x^-1 step.
module mod_p_shift_seq #(
    parameter int M     = 593,
    parameter int T     = 112,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2*M-1:0]   b,
    input  logic [CNT_W-1:0] k,
`ifdef INVERSE_SHIFT_EN
    input  logic             dir,
`endif
    output logic             ready,
    output logic             done,
    output logic [2*M-1:0]   c
);

    // Handshake: start is taken on a rising edge only while ready=1 and is otherwise
    // ignored; done pulses for one cycle and c then holds until the next accepted start.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [2*M-1:0]   acc;
    logic [CNT_W-1:0] count;
    logic [2*M-1:0]   b_clean;
    logic [2*M-1:0]   fwd_acc;
    logic [2*M-1:0]   step_acc;

    function automatic logic [1:0] gf3_add(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= 3'd3) ? s[1:0] - 2'd3 : s[1:0];
    endfunction

    function automatic logic [1:0] gf3_neg(input logic [1:0] y);
        return {y[0], y[1]};
    endfunction

    // The non-canonical digit 11 is folded to 0 on capture so acc stays canonical.
    always_comb begin
        b_clean = '0;
        for (int i = 0; i < M; i++) begin
            b_clean[2*i +: 2] = (b[2*i +: 2] == 2'b11) ? 2'b00 : b[2*i +: 2];
        end
    end

    // x^M = 1 - x^T: the outgoing top digit wraps to position 0 and is subtracted at T.
    always_comb begin
        fwd_acc = '0;
        for (int i = 1; i < M; i++) begin
            fwd_acc[2*i +: 2] = acc[2*(i-1) +: 2];
        end
        fwd_acc[1:0]       = acc[2*(M-1) +: 2];
        fwd_acc[2*T +: 2]  = gf3_add(acc[2*(T-1) +: 2], gf3_neg(acc[2*(M-1) +: 2]));
    end

`ifdef INVERSE_SHIFT_EN
    logic           dir_q;
    logic [2*M-1:0] inv_acc;

    // x^-1 = x^(M-1) + x^(T-1): the outgoing digit 0 lands at M-1 and is added at T-1.
    always_comb begin
        inv_acc = '0;
        for (int i = 0; i < M - 1; i++) begin
            inv_acc[2*i +: 2] = acc[2*(i+1) +: 2];
        end
        inv_acc[2*(M-1) +: 2] = acc[1:0];
        inv_acc[2*(T-1) +: 2] = gf3_add(acc[2*T +: 2], acc[1:0]);
    end

    assign step_acc = dir_q ? inv_acc : fwd_acc;
`else
    assign step_acc = fwd_acc;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            acc   <= '0;
            count <= '0;
`ifdef INVERSE_SHIFT_EN
            dir_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start && ready) begin
                        acc   <= b_clean;
                        count <= k;
`ifdef INVERSE_SHIFT_EN
                        dir_q <= dir;
`endif
                        state <= RUN;
                        ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (count != '0) begin
                        acc   <= step_acc;
                        count <= count - CNT_W'(1);
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign c = acc;

endmodule
